// File: rtl/br_amba_axi_burst_addr_gen_pkg.sv
// Package br_amba: AXI burst types plus helpers for the address generator.
// Provides axi_burst_type_t, the 4KB boundary size, wrap-length and alignment helpers.
package br_amba;

    typedef enum logic [1:0] {
        AxiBurstFixed = 2'b00,
        AxiBurstIncr  = 2'b01,
        AxiBurstWrap  = 2'b10,
        AxiBurstRsvd  = 2'b11
    } axi_burst_type_t;

    typedef enum logic {
        GenIdle,
        GenBusy
    } gen_state_t;

    localparam int AxiBoundaryBytes = 4096;

    // Byte-lane index width; a one-byte bus still gets a 1-bit lane field.
    function automatic int lane_width(int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

    function automatic logic is_legal_wrap_len(logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

    // FIXED bursts keep the raw address; all other types align to 1<<size.
    // Addresses up to 64 bits are supported.
    function automatic logic [63:0] align_addr(
        logic [63:0]     addr,
        logic [2:0]      size,
        axi_burst_type_t burst
    );
        if (burst == AxiBurstFixed) begin
            return addr;
        end
        return addr & ~((64'd1 << size) - 64'd1);
    endfunction

endpackage

// File: rtl/br_amba_axi_burst_addr_gen_if.sv
// Command and beat channels of the AXI burst address generator.
// master: issues cmd_*, accepts beat_*; slave: the generator side.
interface br_amba_axi_burst_addr_gen_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
);
    import br_amba::*;

    localparam int L = lane_width(DataWidth);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IdWidth-1:0]   cmd_id;
    logic [AddrWidth-1:0] cmd_addr;
    logic [7:0]           cmd_len;
    logic [2:0]           cmd_size;
    axi_burst_type_t      cmd_burst;

    logic                 beat_valid;
    logic                 beat_ready;
    logic [IdWidth-1:0]   beat_id;
    logic [AddrWidth-1:0] beat_addr;
    logic [7:0]           beat_idx;
    logic                 beat_last;
    logic [L-1:0]         beat_lane_lo;
    logic [L-1:0]         beat_lane_hi;
    logic                 beat_err;

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output beat_ready,
        input  cmd_ready,
        input  beat_valid, beat_id, beat_addr, beat_idx, beat_last,
        input  beat_lane_lo, beat_lane_hi, beat_err
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  beat_ready,
        output cmd_ready,
        output beat_valid, beat_id, beat_addr, beat_idx, beat_last,
        output beat_lane_lo, beat_lane_hi, beat_err
    );

endinterface

// File: rtl/br_amba_axi_burst_addr_gen_next.sv
// br_amba_axi_burst_addr_next: combinational next-beat address and lane bounds.
// Ports: addr/size/burst/wrap_lo/wrap_end -> next_addr; lane_addr/lane_size -> lane_lo/lane_hi.
module br_amba_axi_burst_addr_next
    import br_amba::*;
#(
    parameter int AddrWidth = 32,
    parameter int L         = 2
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [2:0]           size,
    input  axi_burst_type_t      burst,
    input  logic [AddrWidth-1:0] wrap_lo,
    input  logic [AddrWidth-1:0] wrap_end,
    input  logic [L-1:0]         lane_addr,
    input  logic [2:0]           lane_size,
    output logic [AddrWidth-1:0] next_addr,
    output logic [L-1:0]         lane_lo,
    output logic [L-1:0]         lane_hi
);

    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] incr;
    logic [L-1:0]         lmask;

    always_comb begin
        base      = AddrWidth'(align_addr(64'(addr), size, burst));
        incr      = base + (AddrWidth'(1) << size);
        next_addr = incr;
        unique case (burst)
            AxiBurstFixed: next_addr = base;
            // wrap_end is low+T truncated, so wrapping at the top of the
            // address space still lands back on the wrap boundary
            AxiBurstWrap:  next_addr = (incr == wrap_end) ? wrap_lo : incr;
            default:       next_addr = incr;
        endcase

        // Sizes wider than the bus saturate the mask to all lanes.
        lmask   = L'((8'd1 << lane_size) - 8'd1);
        lane_lo = lane_addr;
        lane_hi = (lane_addr & ~lmask) + lmask;
    end

endmodule

// File: rtl/br_amba_axi_burst_addr_gen.sv
// AXI burst address generator: expands one AW/AR command into per-beat address,
// index, last, byte-lane bounds and error flag. Ports: clk, rst (async, high), bus (slave).
// Option BR_AMBA_AXI_BURST_ADDR_GEN_4KB_CHECK_EN flags INCR bursts crossing 4KB.
module br_amba_axi_burst_addr_gen
    import br_amba::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
) (
    input logic clk,
    input logic rst,
    br_amba_axi_burst_addr_gen_if.slave bus
);

    localparam int         L         = lane_width(DataWidth);
    localparam logic [2:0] LSize     = 3'(L);
    localparam int         BoundBits = $clog2(AxiBoundaryBytes);

    gen_state_t           state;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    axi_burst_type_t      burst_q;
    logic [AddrWidth-1:0] wrap_lo_q;
    logic [AddrWidth-1:0] wrap_end_q;

    logic                 take_cmd;
    logic                 beat_hs;
    logic [7:0]           idx_nxt;

    logic [AddrWidth:0]   cmd_t;
    logic [AddrWidth-1:0] cmd_a;
    logic [AddrWidth-1:0] cmd_lo;
    logic [AddrWidth-1:0] cmd_wend;
    logic                 cmd_illegal;
    logic                 cmd_err;
    axi_burst_type_t      cmd_eff;

`ifdef BR_AMBA_AXI_BURST_ADDR_GEN_4KB_CHECK_EN
    logic [AddrWidth:0]   cmd_a_x;
    logic [AddrWidth:0]   cmd_end;
    logic                 cross_4k;
`endif

    logic [AddrWidth-1:0] next_addr;
    logic [L-1:0]         ld_lane_addr;
    logic [2:0]           ld_size;
    logic [L-1:0]         ld_lane_lo;
    logic [L-1:0]         ld_lane_hi;

    // Held low through reset so nothing is accepted before the FSM is live.
    assign bus.cmd_ready = !rst &&
        ((state == GenIdle) ||
         (bus.beat_valid && bus.beat_ready && bus.beat_last));

    assign take_cmd = bus.cmd_valid && bus.cmd_ready;
    assign beat_hs  = bus.beat_valid && bus.beat_ready;
    assign idx_nxt  = bus.beat_idx + 8'd1;

    always_comb begin
        cmd_a  = AddrWidth'(align_addr(64'(bus.cmd_addr), bus.cmd_size,
                                       AxiBurstIncr));
        // T is one bit wider than the address so 256 x 128B cannot overflow.
        cmd_t  = (AddrWidth+1)'({1'b0, bus.cmd_len} + 9'd1) << bus.cmd_size;
        cmd_lo = bus.cmd_addr & ~AddrWidth'(cmd_t - (AddrWidth+1)'(1));
        cmd_wend = AddrWidth'({1'b0, cmd_lo} + cmd_t);

        cmd_illegal = (bus.cmd_burst == AxiBurstRsvd) ||
                      (bus.cmd_size > LSize) ||
                      ((bus.cmd_burst == AxiBurstWrap) &&
                       (!is_legal_wrap_len(bus.cmd_len) ||
                        (bus.cmd_addr != cmd_a)));

        // Illegal bursts still walk their beats, using INCR addressing.
        cmd_eff = cmd_illegal ? AxiBurstIncr : bus.cmd_burst;

`ifdef BR_AMBA_AXI_BURST_ADDR_GEN_4KB_CHECK_EN
        cmd_a_x  = {1'b0, cmd_a};
        cmd_end  = cmd_a_x + cmd_t - (AddrWidth+1)'(1);
        cross_4k = (cmd_end >> BoundBits) != (cmd_a_x >> BoundBits);
        cmd_err  = cmd_illegal ||
                   ((bus.cmd_burst == AxiBurstIncr) && cross_4k);
`else
        cmd_err  = cmd_illegal;
`endif
    end

    // Lanes are computed for whichever address is loaded next.
    assign ld_lane_addr = take_cmd ? bus.cmd_addr[L-1:0] : next_addr[L-1:0];
    assign ld_size      = take_cmd ? bus.cmd_size : size_q;

    br_amba_axi_burst_addr_next #(
        .AddrWidth (AddrWidth),
        .L         (L)
    ) u_next (
        .addr      (bus.beat_addr),
        .size      (size_q),
        .burst     (burst_q),
        .wrap_lo   (wrap_lo_q),
        .wrap_end  (wrap_end_q),
        .lane_addr (ld_lane_addr),
        .lane_size (ld_size),
        .next_addr (next_addr),
        .lane_lo   (ld_lane_lo),
        .lane_hi   (ld_lane_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= GenIdle;
            len_q            <= '0;
            size_q           <= '0;
            burst_q          <= AxiBurstFixed;
            wrap_lo_q        <= '0;
            wrap_end_q       <= '0;
            bus.beat_valid   <= 1'b0;
            bus.beat_id      <= IdWidth'(0);
            bus.beat_addr    <= '0;
            bus.beat_idx     <= '0;
            bus.beat_last    <= 1'b0;
            bus.beat_lane_lo <= '0;
            bus.beat_lane_hi <= '0;
            bus.beat_err     <= 1'b0;
        end else if (take_cmd) begin
            state            <= GenBusy;
            len_q            <= bus.cmd_len;
            size_q           <= bus.cmd_size;
            burst_q          <= cmd_eff;
            wrap_lo_q        <= cmd_lo;
            wrap_end_q       <= cmd_wend;
            bus.beat_valid   <= 1'b1;
            bus.beat_id      <= bus.cmd_id;
            bus.beat_addr    <= bus.cmd_addr;
            bus.beat_idx     <= '0;
            bus.beat_last    <= (bus.cmd_len == 8'd0);
            bus.beat_lane_lo <= ld_lane_lo;
            bus.beat_lane_hi <= ld_lane_hi;
            bus.beat_err     <= cmd_err;
        end else if (beat_hs) begin
            if (bus.beat_last) begin
                state          <= GenIdle;
                bus.beat_valid <= 1'b0;
            end else begin
                bus.beat_addr    <= next_addr;
                bus.beat_idx     <= idx_nxt;
                bus.beat_last    <= (idx_nxt == len_q);
                bus.beat_lane_lo <= ld_lane_lo;
                bus.beat_lane_hi <= ld_lane_hi;
            end
        end
    end

endmodule

// File: tb/tb_br_amba_axi_burst_addr_gen.sv
// Self-checking bench for br_amba_axi_burst_addr_gen (32-bit and 64-bit data instances).
// Directed commands push expected beats; per-instance monitors pop and compare.
module tb_br_amba_axi_burst_addr_gen;
    import br_amba::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    br_amba_axi_burst_addr_gen_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(4)) b32 ();
    br_amba_axi_burst_addr_gen_if #(.AddrWidth(32), .DataWidth(64), .IdWidth(4)) b64 ();

    br_amba_axi_burst_addr_gen #(.AddrWidth(32), .DataWidth(32), .IdWidth(4)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    br_amba_axi_burst_addr_gen #(.AddrWidth(32), .DataWidth(64), .IdWidth(4)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

`ifdef BR_AMBA_AXI_BURST_ADDR_GEN_4KB_CHECK_EN
    localparam logic Err4k = 1'b1;
`else
    localparam logic Err4k = 1'b0;
`endif

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  idx;
        logic        last;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32;
    exp_t e64;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expb(int inst, logic [3:0] id, logic [31:0] a,
                        logic [7:0] idx, logic last, logic [7:0] lo,
                        logic [7:0] hi, logic err);
        exp_t e;
        e.id = id; e.addr = a; e.idx = idx; e.last = last;
        e.lo = lo; e.hi = hi; e.err = err;
        if (inst == 0) q32.push_back(e);
        else           q64.push_back(e);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && b32.beat_valid && b32.beat_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b32 extra beat got=%0h want=none", b32.beat_addr);
            end else begin
                e32 = q32.pop_front();
                chk("b32 addr", b32.beat_addr, e32.addr);
                chk("b32 idx",  32'(b32.beat_idx), 32'(e32.idx));
                chk("b32 last", 32'(b32.beat_last), 32'(e32.last));
                chk("b32 lo",   32'(b32.beat_lane_lo), 32'(e32.lo));
                chk("b32 hi",   32'(b32.beat_lane_hi), 32'(e32.hi));
                chk("b32 err",  32'(b32.beat_err), 32'(e32.err));
                chk("b32 id",   32'(b32.beat_id), 32'(e32.id));
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst && b64.beat_valid && b64.beat_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b64 extra beat got=%0h want=none", b64.beat_addr);
            end else begin
                e64 = q64.pop_front();
                chk("b64 addr", b64.beat_addr, e64.addr);
                chk("b64 idx",  32'(b64.beat_idx), 32'(e64.idx));
                chk("b64 last", 32'(b64.beat_last), 32'(e64.last));
                chk("b64 lo",   32'(b64.beat_lane_lo), 32'(e64.lo));
                chk("b64 hi",   32'(b64.beat_lane_hi), 32'(e64.hi));
                chk("b64 err",  32'(b64.beat_err), 32'(e64.err));
                chk("b64 id",   32'(b64.beat_id), 32'(e64.id));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    // with beat 0 of the new burst expected on the outputs.
    task automatic send(int inst, logic [3:0] id, logic [31:0] addr,
                        logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        int n = 0;
        logic rdy;
        if (inst == 0) begin
            b32.cmd_valid = 1'b1; b32.cmd_id = id; b32.cmd_addr = addr;
            b32.cmd_len = len; b32.cmd_size = size;
            b32.cmd_burst = axi_burst_type_t'(burst);
        end else begin
            b64.cmd_valid = 1'b1; b64.cmd_id = id; b64.cmd_addr = addr;
            b64.cmd_len = len; b64.cmd_size = size;
            b64.cmd_burst = axi_burst_type_t'(burst);
        end
        #1;
        rdy = (inst == 0) ? b32.cmd_ready : b64.cmd_ready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            rdy = (inst == 0) ? b32.cmd_ready : b64.cmd_ready;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL cmd accept timeout got=0 want=1 addr=%0h", addr);
        end
        @(posedge clk);
        @(negedge clk);
        if (inst == 0) begin
            b32.cmd_valid = 1'b0;
            chk("beat0 valid", 32'(b32.beat_valid), 32'd1);
            chk("beat0 addr", b32.beat_addr, addr);
        end else begin
            b64.cmd_valid = 1'b0;
            chk("beat0 valid", 32'(b64.beat_valid), 32'd1);
            chk("beat0 addr", b64.beat_addr, addr);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0 || q64.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout got=%0d want=0", q32.size() + q64.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        b32.cmd_valid = 0; b32.cmd_id = 0; b32.cmd_addr = 0; b32.cmd_len = 0;
        b32.cmd_size = 0; b32.cmd_burst = AxiBurstFixed; b32.beat_ready = 1;
        b64.cmd_valid = 0; b64.cmd_id = 0; b64.cmd_addr = 0; b64.cmd_len = 0;
        b64.cmd_size = 0; b64.cmd_burst = AxiBurstFixed; b64.beat_ready = 1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst cmd_ready", 32'(b32.cmd_ready), 32'd0);
        chk("rst beat_valid", 32'(b32.beat_valid), 32'd0);
        chk("rst beat_addr", b32.beat_addr, 32'd0);
        chk("rst beat_err", 32'(b32.beat_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst cmd_ready", 32'(b32.cmd_ready), 32'd1);
        chk("post-rst beat_valid", 32'(b32.beat_valid), 32'd0);
        @(negedge clk);

        // INCR 0x1004 len3 size2 with a 3-cycle stall on beat 0
        expb(0, 4'd1, 32'h1004, 0, 0, 0, 3, 0);
        expb(0, 4'd1, 32'h1008, 1, 0, 0, 3, 0);
        expb(0, 4'd1, 32'h100C, 2, 0, 0, 3, 0);
        expb(0, 4'd1, 32'h1010, 3, 1, 0, 3, 0);
        send(0, 4'd1, 32'h1004, 8'd3, 3'd2, 2'b01);
        b32.beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stall valid", 32'(b32.beat_valid), 32'd1);
            chk("stall addr", b32.beat_addr, 32'h1004);
            chk("stall idx", 32'(b32.beat_idx), 32'd0);
            chk("stall cmd_ready", 32'(b32.cmd_ready), 32'd0);
        end
        @(negedge clk);
        b32.beat_ready = 1'b1;
        wait_done();

        // FIXED 0x2002 len2 size0
        for (int i = 0; i < 3; i++)
            expb(0, 4'd2, 32'h2002, 8'(i), (i == 2), 2, 2, 0);
        send(0, 4'd2, 32'h2002, 8'd2, 3'd0, 2'b00);
        wait_done();

        // INCR unaligned 0x1003 len1 size2
        expb(0, 4'd3, 32'h1003, 0, 0, 3, 3, 0);
        expb(0, 4'd3, 32'h1004, 1, 1, 0, 3, 0);
        send(0, 4'd3, 32'h1003, 8'd1, 3'd2, 2'b01);
        wait_done();

        // WRAP 0x1038 len3 size2 on the 32-bit bus: wraps within 0x1030..0x103F
        expb(0, 4'd4, 32'h1038, 0, 0, 0, 3, 0);
        expb(0, 4'd4, 32'h103C, 1, 0, 0, 3, 0);
        expb(0, 4'd4, 32'h1030, 2, 0, 0, 3, 0);
        expb(0, 4'd4, 32'h1034, 3, 1, 0, 3, 0);
        send(0, 4'd4, 32'h1038, 8'd3, 3'd2, 2'b10);
        wait_done();

        // Back-to-back: second command taken on the first's last handshake
        expb(0, 4'd5, 32'h3000, 0, 0, 0, 3, 0);
        expb(0, 4'd5, 32'h3004, 1, 1, 0, 3, 0);
        expb(0, 4'd6, 32'h4001, 0, 1, 1, 1, 0);
        send(0, 4'd5, 32'h3000, 8'd1, 3'd2, 2'b01);
        send(0, 4'd6, 32'h4001, 8'd0, 3'd0, 2'b00);
        wait_done();

        // Reserved burst: INCR addresses, err on every beat
        expb(0, 4'd7, 32'h5000, 0, 0, 0, 3, 1);
        expb(0, 4'd7, 32'h5004, 1, 1, 0, 3, 1);
        send(0, 4'd7, 32'h5000, 8'd1, 3'd2, 2'b11);
        wait_done();

        // WRAP with len2 is illegal
        expb(0, 4'd8, 32'h6000, 0, 0, 0, 3, 1);
        expb(0, 4'd8, 32'h6004, 1, 0, 0, 3, 1);
        expb(0, 4'd8, 32'h6008, 2, 1, 0, 3, 1);
        send(0, 4'd8, 32'h6000, 8'd2, 3'd2, 2'b10);
        wait_done();

        // INCR crossing 4KB
        expb(0, 4'd9, 32'h0FF8, 0, 0, 0, 3, Err4k);
        expb(0, 4'd9, 32'h0FFC, 1, 0, 0, 3, Err4k);
        expb(0, 4'd9, 32'h1000, 2, 0, 0, 3, Err4k);
        expb(0, 4'd9, 32'h1004, 3, 1, 0, 3, Err4k);
        send(0, 4'd9, 32'h0FF8, 8'd3, 3'd2, 2'b01);
        wait_done();

        // WRAP with unaligned address is illegal
        expb(0, 4'd10, 32'h1039, 0, 0, 1, 3, 1);
        expb(0, 4'd10, 32'h103C, 1, 0, 0, 3, 1);
        expb(0, 4'd10, 32'h1040, 2, 0, 0, 3, 1);
        expb(0, 4'd10, 32'h1044, 3, 1, 0, 3, 1);
        send(0, 4'd10, 32'h1039, 8'd3, 3'd2, 2'b10);
        wait_done();

        // size wider than the 32-bit bus
        expb(0, 4'd11, 32'h7000, 0, 1, 0, 3, 1);
        send(0, 4'd11, 32'h7000, 8'd0, 3'd3, 2'b01);
        wait_done();

        // WRAP 0x1038 len3 size3 on the 64-bit bus
        expb(1, 4'd12, 32'h1038, 0, 0, 0, 7, 0);
        expb(1, 4'd12, 32'h1020, 1, 0, 0, 7, 0);
        expb(1, 4'd12, 32'h1028, 2, 0, 0, 7, 0);
        expb(1, 4'd12, 32'h1030, 3, 1, 0, 7, 0);
        send(1, 4'd12, 32'h1038, 8'd3, 3'd3, 2'b10);
        wait_done();

        // Reset in the middle of a burst drops it at once
        send(0, 4'd13, 32'h8000, 8'd3, 3'd2, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst beat_valid", 32'(b32.beat_valid), 32'd0);
        chk("midrst cmd_ready", 32'(b32.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst release cmd_ready", 32'(b32.cmd_ready), 32'd1);
        chk("midrst release valid", 32'(b32.beat_valid), 32'd0);
        @(negedge clk);

        expb(0, 4'd14, 32'h9000, 0, 1, 0, 3, 0);
        send(0, 4'd14, 32'h9000, 8'd0, 3'd2, 2'b01);
        wait_done();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
